// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// MCU-side read/status bus of the UART receiver (master = MCU, slave = receiver).
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 8);
  import uart_rx_pkg::*;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd_pop;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              frame_err;
  logic              parity_err;
  logic              rx_busy;

  modport master (
    output rd_pop, clr_err,
    input  rd_data, rd_valid, fifo_count, overflow, frame_err, parity_err, rx_busy
  );

  modport slave (
    input  rd_pop, clr_err,
    output rd_data, rd_valid, fifo_count, overflow, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo_fifo_sync.sv
// Synchronous FIFO with a registered head (rdata/empty lag the write edge by one cycle).
module fifo_sync #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = ~valid_q;
  assign rdata = rdata_q;
  assign count = count_q;

  always_comb begin
    // valid_q can lag a pop by a cycle, so the live count also gates the pop
    do_pop   = pop && valid_q && (count_q != '0);
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop)
      count_d = count_q + CW'(1);
    else if (do_pop && !do_push)
      count_d = count_q - CW'(1);
    rdata_d  = mem_q[rd_ptr_q];
    valid_d  = (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte FIFO.
// Holds the rx synchroniser, bit timer, receive FSM, shift register and sticky flags.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;
  localparam int BIDX_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  BIT_LD    = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  HALF_LD   = CNT_W'(HALF - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] live_q, live_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   rx_s, start_edge;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIDX_W-1:0] bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              busy_q, push_q, frame_set_q;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_set_q;
  logic              parity_err_q, parity_err_d;
`endif

  logic              overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic              fifo_empty, fifo_full, pop_req;
  logic [FCW-1:0]    fifo_count;
  logic [DATA_W-1:0] fifo_rdata;

  // Synchroniser presets read as idle-high, so a start is only accepted once a
  // genuinely sampled high has passed through (live_q tracks real samples).
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    live_d     = {live_q[SYNC_STAGES-2:0], 1'b1};
    rx_s       = sync_q[SYNC_STAGES-1];
    prev_d     = rx_s;
    armed_d    = armed_q | (live_q[SYNC_STAGES-1] & rx_s);
    start_edge = armed_q & prev_q & ~rx_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      live_q  <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      live_q  <= live_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_set_q   <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_set_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q <= START;
            cnt_q   <= HALF_LD;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              cnt_q   <= BIT_LD;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s, shift_q[DATA_W-1:1]};
            cnt_q   <= BIT_LD;
            bit_q   <= bit_q + BIDX_W'(1);
            if (bit_q == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == '0) begin
            par_bad_q <= rx_s ^ (^shift_q);
            cnt_q     <= BIT_LD;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Back to IDLE mid-stop-bit so the next start edge is caught without a gap
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!rx_s)
              frame_set_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_bad_q)
              par_set_q <= 1'b1;
`endif
            else
              push_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .pop   (bus.rd_pop),
    .wdata (shift_q),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign pop_req = bus.rd_pop & ~fifo_empty;

  always_comb begin
    overflow_d   = (push_q & fifo_full & ~pop_req) | (overflow_q & ~bus.clr_err);
    frame_err_d  = frame_set_q | (frame_err_q & ~bus.clr_err);
`ifdef UART_RX_PARITY_EN
    parity_err_d = par_set_q | (parity_err_q & ~bus.clr_err);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rd_data    = fifo_rdata;
  assign bus.rd_valid   = ~fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, results compared to a queue model.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
`else
  localparam bit PAR_EN   = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;
  localparam int LAT_MIN    = (FRAME_BITS - 1) * BIT - 10;
  localparam int LAT_MAX    = FRAME_BITS * BIT + 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         ovf_m, fe_m, pe_m;
  int         lat;
  logic [7:0] b;
  bit         stop_ok, flip, saw_busy;
  int         npop;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ par_flip);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit s_ok, input bit p_ok);
    if (!s_ok)                fe_m = 1'b1;
    else if (!p_ok)           pe_m = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else                      ovf_m = 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    fe_m  = 1'b0;
    pe_m  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":count"}, bus.fifo_count, q.size());
    chk({tag, ":valid"}, bus.rd_valid, q.size() != 0);
    if (q.size() != 0) chk({tag, ":head"}, bus.rd_data, q[0]);
    chk({tag, ":overflow"}, bus.overflow, ovf_m);
    chk({tag, ":frame_err"}, bus.frame_err, fe_m);
    chk({tag, ":parity_err"}, bus.parity_err, pe_m);
    chk({tag, ":busy"}, bus.rx_busy, 0);
  endtask

  task automatic pop_one(input string tag);
    bus.rd_pop = 1'b1;
    tick(1);
    bus.rd_pop = 1'b0;
    tick(1);
    if (q.size() != 0) void'(q.pop_front());
    check_all(tag);
  endtask

  task automatic clr(input string tag);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(1);
    ovf_m = 1'b0;
    fe_m  = 1'b0;
    pe_m  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks so far %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_pop  = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    tick(3);
    check_all("reset_held");
    chk("reset_held:rd_data", bus.rd_data, 0);
    reset = 1'b0;
    tick(5);
    check_all("reset_released");

    // single byte, latency and pop
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (!bus.rd_valid && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    model_frame(8'hA5, 1'b1, 1'b1);
    chk("t1_latency_window", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    check_all("t1");
    pop_one("t1_pop");
    pop_one("t1_pop_empty");

    // back-to-back frames into a full FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_frame(8'(i), 1'b1, 1'b1);
    end
    check_all("t2_full");
    chk("t2_overflow_set", bus.overflow, 1);
    for (int i = 0; i < 4; i++) pop_one("t2_drain");
    clr("t2_clr");

    // short low glitch is a false start
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.rx_busy) saw_busy = 1'b1;
    end
    chk("t3_glitch_seen", saw_busy, 1);
    check_all("t3_glitch");

    // framing error, clear, then good byte
    send_frame(8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b1);
    check_all("t4_frame_err");
    tick(20);
    clr("t4_clr");
    send_frame(8'h3C, 1'b1, 1'b0);
    model_frame(8'h3C, 1'b1, 1'b1);
    check_all("t4_good");
    pop_one("t4_pop");

    // push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_frame(b, 1'b1, 1'b1);
    end
    check_all("t5_full");
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        tick(lat - 2);
        bus.rd_pop = 1'b1;
        tick(1);
        bus.rd_pop = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'h77);
    check_all("t5_push_pop");
    for (int i = 0; i < DEPTH; i++) pop_one("t5_drain");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b1);
    model_frame(8'h0F, 1'b1, 1'b0);
    check_all("t6_parity_bad");
    send_frame(8'h0F, 1'b1, 1'b0);
    model_frame(8'h0F, 1'b1, 1'b1);
    check_all("t6_parity_good");
    pop_one("t6_pop");
    clr("t6_clr");
`endif

    // reset in the middle of a frame
    send_frame(8'h5A, 1'b1, 1'b0);
    model_frame(8'h5A, 1'b1, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    chk("t7_busy_mid_frame", bus.rx_busy, 1);
    reset = 1'b1;
    tick(2);
    model_reset();
    check_all("t7_in_reset");
    chk("t7_in_reset:rd_data", bus.rd_data, 0);
    rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);
    check_all("t7_after_reset");

    // line held low across reset release is not a start
    reset = 1'b1;
    rx = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(60);
    check_all("t7_low_after_reset");
    rx = 1'b1;
    tick(40);
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0);
    model_frame(b, 1'b1, 1'b1);
    check_all("t7_first_frame");
    pop_one("t7_pop");

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 7) != 0);
      flip    = PAR_EN && ($urandom_range(0, 5) == 0);
      send_frame(b, stop_ok, flip);
      model_frame(b, stop_ok, !flip);
      check_all("rnd_frame");
      npop = $urandom_range(0, 2);
      repeat (npop) pop_one("rnd_pop");
      if ($urandom_range(0, 4) == 0) clr("rnd_clr");
      tick(stop_ok ? $urandom_range(0, 6) : 20 + $urandom_range(0, 6));
    end
    while (q.size() != 0) pop_one("final_drain");
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
